sbox8_ti_r3_stage: RTL and testbench
====================================

# sbox8_ti_r3_stage

Elastic, share-preserving pipeline register between the round-3 component functions of the 8-bit threshold-implementation S-box and the round-4 input.
- Captures the SHARES×WIDTH component-function output bits (one bit per output-coordinate/share pair) under a valid/ready handshake.
- Optionally refreshes the sharing with fresh randomness.
- Presents the result to the next round through a two-entry skid buffer, so neither side stalls combinationally.
- Sharing is never recombined inside the block: no path XORs shares of the same coordinate together.

## Interface
Parameters:
- SHARES, 4, number of shares per coordinate (≥3).
- WIDTH, 8, coordinates per share (S-box width).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream component-function outputs valid.
- in_ready  out  1  stage can accept this cycle.
- in_shares  in  SHARES*WIDTH  share s, coordinate c at bit s*WIDTH+c.
- rnd  in  (SHARES-1)*WIDTH  fresh randomness; sampled only on an accepted transfer.
- out_valid  out  1  out_shares holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_shares  out  SHARES*WIDTH  registered shares, same packing as in_shares.
- xfer_cnt  out  16  count of accepted input transfers, wraps 0xFFFF→0x0000.

## Operation
- Accept when in_valid & in_ready. Emit when out_valid & out_ready.
- Storage: main register M (drives out_shares), skid register S.
- FSM states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: M valid; in_ready=1, out_valid=1.
  - FULL: M and S valid; in_ready=0, out_valid=1.
- Transitions:
  - EMPTY + accept → ONE; data goes to M.
  - ONE + accept & emit → ONE; data goes to M.
  - ONE + accept, no emit → FULL; data goes to S.
  - ONE + emit, no accept → EMPTY.
  - FULL + emit → ONE; S moves to M.
  - FULL, no emit → FULL; M and S hold.
- in_ready is a registered function of state only; it has no combinational dependence on out_ready.
- Captured value w is in_shares after optional refresh (see Configuration). It is written into M or S exactly as computed.
- xfer_cnt increments by 1 on every accept, modulo 2^16.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_shares is held stable.

## Timing
- Reset values: state=EMPTY, M=0, S=0, out_shares=0, out_valid=0, in_ready=1, xfer_cnt=0.
- Reset asserted mid-operation discards M and S on the next edge, regardless of the handshake signals in that cycle.
- Latency: accept in cycle n → out_valid=1 from cycle n+1, for an entry written into empty M.
- Throughput: one transfer per cycle when out_ready is held high.
- Simultaneous accept and emit in ONE keeps occupancy at 1 and replaces M.
- rnd is consumed only in cycles with an accept. Randomness offered in other cycles is ignored.

## Configuration
- Macro STIS8_R3_REFRESH_EN.
- Defined: let r_s = rnd[s*WIDTH +: WIDTH].
  - Shares s=0..SHARES-2 are stored as in_share_s ^ r_s.
  - The last share is stored as in_share_{SHARES-1} ^ r_0 ^ … ^ r_{SHARES-2}.
  - The XOR of all shares per coordinate is therefore unchanged.
- Not defined: w = in_shares. The rnd port remains but is unused; it must not be removed.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, out_shares=0, xfer_cnt=0; no capture occurs.
- Streaming: out_ready=1, feed in_shares=0x01234567, then 0x89ABCDEF on consecutive cycles (macro off) → out_shares shows them in cycles n+1 and n+2; xfer_cnt=2.
- Backpressure: out_ready=0, offer three entries A, B, C → A and B accepted, then in_ready=0 and C is held off. Raise out_ready → A, B, C emitted in order with no gaps after C is accepted.
- Refresh (macro on, SHARES=4, WIDTH=8): in_shares=0xA5A5A5A5, rnd=0x112233 → the XOR of the four output bytes equals 0x00, matching the input. The bytes themselves are input_byte ^ r per the refresh rule.
- Mid-operation reset: state FULL, assert rst for one cycle → next cycle EMPTY, out_valid=0, and previously buffered data never appears.
- Counter wrap: preload through 65535 accepts, accept 1 more → xfer_cnt=0x0000.

Source files
------------

// File: rtl/sbox8_ti_r3_stage.sv
// rtl/sbox8_ti_r3_stage.sv - round-3 to round-4 share-preserving elastic stage with two-entry skid buffer
// Optional sharing refresh enabled by defining STIS8_R3_REFRESH_EN.
module sbox8_ti_r3_stage #(
   parameter int SHARES = 4,
   parameter int WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SHARES*WIDTH-1:0]       in_shares,
   input  logic [(SHARES-1)*WIDTH-1:0]   rnd,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SHARES*WIDTH-1:0]       out_shares,
   output logic [15:0]                   xfer_cnt
);

   localparam int N = SHARES * WIDTH;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   m_reg;
   logic [N-1:0]   s_reg;
   logic [N-1:0]   w;
   logic [15:0]    cnt_reg;
   logic           accept;
   logic           emit;
   logic           load_m_w;
   logic           load_m_s;
   logic           load_s_w;

   // Handshake outputs decode the state register only, never out_ready.
   assign in_ready   = (state != ST_FULL);
   assign out_valid  = (state != ST_EMPTY);
   assign accept     = in_valid & in_ready;
   assign emit       = out_valid & out_ready;
   assign out_shares = m_reg;
   assign xfer_cnt   = cnt_reg;

`ifdef STIS8_R3_REFRESH_EN
   logic [WIDTH-1:0] r_sum;

   // Only randomness is folded into the last share; shares are never mixed with each other.
   always_comb begin
      r_sum = '0;
      w     = in_shares;
      for (int s = 0; s < SHARES - 1; s++) begin
         w[s*WIDTH +: WIDTH] = in_shares[s*WIDTH +: WIDTH] ^ rnd[s*WIDTH +: WIDTH];
         r_sum               = r_sum ^ rnd[s*WIDTH +: WIDTH];
      end
      w[(SHARES-1)*WIDTH +: WIDTH] = in_shares[(SHARES-1)*WIDTH +: WIDTH] ^ r_sum;
   end
`else
   logic unused_rnd;

   assign unused_rnd = ^rnd;
   assign w          = in_shares;
`endif

   always_comb begin
      state_next = state;
      load_m_w   = 1'b0;
      load_m_s   = 1'b0;
      load_s_w   = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               load_m_w   = 1'b1;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && emit) begin
               load_m_w = 1'b1;
            end else if (accept) begin
               load_s_w   = 1'b1;
               state_next = ST_FULL;
            end else if (emit) begin
               state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (emit) begin
               load_m_s   = 1'b1;
               state_next = ST_ONE;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_EMPTY;
         m_reg   <= '0;
         s_reg   <= '0;
         cnt_reg <= '0;
      end else begin
         state <= state_next;
         if (load_m_w) begin
            m_reg <= w;
         end else if (load_m_s) begin
            m_reg <= s_reg;
         end
         if (load_s_w) begin
            s_reg <= w;
         end
         if (accept) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sbox8_ti_r3_stage.sv
// tb/tb_sbox8_ti_r3_stage.sv - self-checking bench for sbox8_ti_r3_stage against a queue-based model
// Expected refresh behaviour follows STIS8_R3_REFRESH_EN when defined.
module tb_sbox8_ti_r3_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_shares;
   logic [23:0] rnd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_shares;
   logic [15:0] xfer_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] q[$];
   logic [15:0] cnt;

   sbox8_ti_r3_stage #(.SHARES(4), .WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_shares  (in_shares),
      .rnd        (rnd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_shares (out_shares),
      .xfer_cnt   (xfer_cnt)
   );

   always #5 clk = ~clk;

   // Refresh as a single mask: bytes r0,r1,r2 on shares 0..2 and their XOR on share 3.
   function automatic logic [31:0] model_w(input logic [31:0] d, input logic [23:0] r);
`ifdef STIS8_R3_REFRESH_EN
      logic [7:0] r_all;
      r_all = r[7:0] ^ r[15:8] ^ r[23:16];
      return d ^ {r_all, r};
`else
      return d;
`endif
   endfunction

   function automatic logic [7:0] xor_bytes(input logic [31:0] x);
      return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, then advance DUT and model together.
   task automatic cycle(input logic rs, input logic v, input logic [31:0] d,
                        input logic [23:0] r, input logic ordy);
      logic acc;
      logic em;
      rst = rs; in_valid = v; in_shares = d; rnd = r; out_ready = ordy;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, cnt});
      if (q.size() > 0) chk("out_shares", out_shares, q[0]);
      acc = v && (q.size() < 2);
      em  = ordy && (q.size() > 0);
      @(posedge clk);
      #1;
      if (rs) begin
         q.delete();
         cnt = 16'd0;
      end else begin
         if (em) void'(q.pop_front());
         if (acc) begin
            q.push_back(model_w(d, r));
            cnt = cnt + 16'd1;
         end
      end
   endtask

   initial begin
      logic [23:0] r0;
      logic [23:0] r1;
      int          guard;

      // Reset held two cycles with in_valid high: nothing may be captured.
      rst = 1'b1; in_valid = 1'b1; in_shares = 32'hDEADBEEF; rnd = 24'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      cnt = 16'd0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_shares", out_shares, 32'd0);
      chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

      // Streaming back to back.
      r0 = 24'($urandom);
      r1 = 24'($urandom);
      cycle(1'b0, 1'b1, 32'h01234567, r0, 1'b1);
      chk("stream_first", out_shares, model_w(32'h01234567, r0));
      cycle(1'b0, 1'b1, 32'h89ABCDEF, r1, 1'b1);
      chk("stream_second", out_shares, model_w(32'h89ABCDEF, r1));
      chk("stream_cnt", {16'd0, xfer_cnt}, 32'd2);
      cycle(1'b0, 1'b0, 32'h0, 24'h0, 1'b1);

      // Backpressure: A and B fill the buffer, C waits until space opens.
      cycle(1'b0, 1'b1, 32'hAAAA0001, 24'($urandom), 1'b0);
      cycle(1'b0, 1'b1, 32'hBBBB0002, 24'($urandom), 1'b0);
      chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      r0 = 24'($urandom);
      repeat (2) cycle(1'b0, 1'b1, 32'hCCCC0003, r0, 1'b0);
      repeat (2) cycle(1'b0, 1'b1, 32'hCCCC0003, r0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 24'h0, 1'b1);

      // Refresh directed vector; the share XOR is preserved in either build.
      cycle(1'b0, 1'b1, 32'hA5A5A5A5, 24'h112233, 1'b0);
      chk("refresh_xor", {24'd0, xor_bytes(out_shares)}, 32'h00);
`ifdef STIS8_R3_REFRESH_EN
      chk("refresh_word", out_shares, 32'hA5B48796);
`else
      chk("refresh_word", out_shares, 32'hA5A5A5A5);
`endif
      cycle(1'b0, 1'b0, 32'h0, 24'($urandom), 1'b1);

      // Mid-operation reset from FULL discards both entries.
      cycle(1'b0, 1'b1, 32'h5EED0001, 24'($urandom), 1'b0);
      cycle(1'b0, 1'b1, 32'h5EED0002, 24'($urandom), 1'b0);
      chk("full_before_rst", {31'd0, in_ready}, 32'd0);
      cycle(1'b1, 1'b1, 32'h5EED0003, 24'($urandom), 1'b1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_shares", out_shares, 32'd0);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 24'h0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 3) != 0), $urandom, 24'($urandom),
               1'($urandom_range(0, 2) != 0));
      end
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 24'h0, 1'b1);

      // Counter wrap.
      guard = 0;
      while (cnt != 16'hFFFF && guard < 70000) begin
         cycle(1'b0, 1'b1, $urandom, 24'($urandom), 1'b1);
         guard++;
      end
      chk("wrap_pre", {16'd0, xfer_cnt}, 32'h0000FFFF);
      cycle(1'b0, 1'b1, 32'h13579BDF, 24'($urandom), 1'b1);
      chk("wrap_zero", {16'd0, xfer_cnt}, 32'h00000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
